// File: rtl/km_merge_pkg.sv
// Shared constants and state encoding for the Karatsuba multiply path.
// The partial-product multiplier and km_merge derive their widths from the same helpers.
package km_merge_pkg;

  typedef enum logic [1:0] {
    S_LO  = 2'd0,
    S_HI  = 2'd1,
    S_MID = 2'd2
  } km_state_e;

  localparam int unsigned KM_DW_DEFAULT = 32;

  function automatic int unsigned km_h(input int unsigned dw);
    return dw / 2;
  endfunction

  // mid = (aL+aH)*(bL+bH) needs two extra bits over a half-product pair
  function automatic int unsigned km_midw(input int unsigned dw);
    return dw + 2;
  endfunction

  function automatic int unsigned km_pw(input int unsigned dw);
    return 2 * dw;
  endfunction

endpackage

// File: rtl/km_pipe_reg.sv
// Single valid/ready register slice carrying data, tag and an error flag.
// Accepts a new entry whenever empty or when the current one leaves in the same cycle.
module km_pipe_reg #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              in_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              err_q, err_d;

  assign in_ready = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    tag_d   = tag_q;
    err_d   = err_q;
    if (in_valid && in_ready) begin
      valid_d = 1'b1;
      data_d  = in_data;
      tag_d   = in_tag;
      err_d   = in_err;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      tag_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_tag   = tag_q;
  assign out_err   = err_q;

endmodule

// File: rtl/km_merge.sv
// Karatsuba recombination: collects lo, hi, mid beats and forms hi*2^DW + (mid-lo-hi)*2^H + lo.
//   state | meaning
//   S_LO  | waiting for lo partial product
//   S_HI  | lo captured, waiting for hi
//   S_MID | lo/hi captured, mid loads stage 1 when it has room
module km_merge
  import km_merge_pkg::*;
#(
  parameter int unsigned DW = KM_DW_DEFAULT,
  parameter int unsigned TW = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW+1:0]   in_data,
  input  logic [TW-1:0]   in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] out_product,
  output logic [TW-1:0]   out_tag,
  output logic            out_err
);

  localparam int unsigned H    = km_h(DW);
  localparam int unsigned MIDW = km_midw(DW);
  localparam int unsigned PW   = km_pw(DW);
  localparam int unsigned S1W  = MIDW + 2 * DW;

  km_state_e       state_q, state_d;
  logic [DW-1:0]   lo_q, lo_d, hi_q, hi_d;
  logic            s1_load_ok, s2_load_ok;
  logic            s1_valid, s1_err, mid_valid;
  logic [S1W-1:0]  s1_data;
  logic [TW-1:0]   s1_tag;
  logic [MIDW:0]   diff;
  logic [MIDW-1:0] s1_corr;
  logic [DW-1:0]   s1_lo, s1_hi;
  logic [PW-1:0]   corr_ext, product;

  assign in_ready  = (state_q != S_MID) || s1_load_ok;
  assign mid_valid = in_valid && (state_q == S_MID);

  // One extra bit on top of MIDW: its value is the borrow-out of mid - lo - hi
  assign diff = {1'b0, in_data} - {3'b000, lo_q} - {3'b000, hi_q};

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    if (in_valid && in_ready) begin
      case (state_q)
        S_LO: begin
          lo_d    = in_data[DW-1:0];
          state_d = S_HI;
        end
        S_HI: begin
          hi_d    = in_data[DW-1:0];
          state_d = S_MID;
        end
        S_MID:   state_d = S_LO;
        default: state_d = S_LO;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_LO;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  km_pipe_reg #(.DATA_W(S1W), .TAG_W(TW)) u_s1 (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (mid_valid),
    .in_ready  (s1_load_ok),
    .in_data   ({diff[MIDW-1:0], hi_q, lo_q}),
    .in_tag    (in_tag),
    .in_err    (diff[MIDW]),
    .out_valid (s1_valid),
    .out_ready (s2_load_ok),
    .out_data  (s1_data),
    .out_tag   (s1_tag),
    .out_err   (s1_err)
  );

  assign {s1_corr, s1_hi, s1_lo} = s1_data;
  assign corr_ext = {{(PW - MIDW){1'b0}}, s1_corr};
  assign product  = {s1_hi, s1_lo} + (corr_ext << H);

  km_pipe_reg #(.DATA_W(PW), .TAG_W(TW)) u_s2 (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (s1_valid),
    .in_ready  (s2_load_ok),
    .in_data   (product),
    .in_tag    (s1_tag),
    .in_err    (s1_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_product),
    .out_tag   (out_tag),
    .out_err   (out_err)
  );

endmodule

// File: tb/tb_km_merge.sv
// Directed bench for km_merge at DW=16: latency, streaming, backpressure, malformed sets, reset.
module tb_km_merge;

  localparam int DW = 16;
  localparam int TW = 4;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW+1:0]   in_data = '0;
  logic [TW-1:0]   in_tag = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [2*DW-1:0] out_product;
  logic [TW-1:0]   out_tag;
  logic            out_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [2*DW-1:0] q_prod[$];
  logic [TW-1:0]   q_tag[$];
  logic            q_err[$];
  int              q_cyc[$];

  km_merge #(.DW(DW), .TW(TW)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .out_tag     (out_tag),
    .out_err     (out_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Record every output handshake; the accept happens at the following rising edge
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      q_prod.push_back(out_product);
      q_tag.push_back(out_tag);
      q_err.push_back(out_err);
      q_cyc.push_back(cyc);
    end
  end

  task automatic clear_q();
    q_prod.delete();
    q_tag.delete();
    q_err.delete();
    q_cyc.delete();
  endtask

  task automatic send_beat(input logic [DW+1:0] d, input logic [TW-1:0] t);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_tag   = t;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL beat_accept: beat %h not accepted within 50 cycles", d);
    end
  endtask

  // lo/hi beats carry junk in the upper bits and tag, both of which must be ignored
  task automatic send_set(input logic [DW-1:0] lo, input logic [DW-1:0] hi,
                          input logic [DW+1:0] mid, input logic [TW-1:0] t);
    send_beat({2'b11, lo}, 4'hF);
    send_beat({2'b11, hi}, 4'hE);
    send_beat(mid, t);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++; if (out_product !== 32'h0) begin bad++; $display("FAIL reset_product: got %h want 0", out_product); end
    total++; if (out_tag !== 4'h0) begin bad++; $display("FAIL reset_tag: got %h want 0", out_tag); end
    total++; if (out_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", out_err); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    clear_q();
    out_ready = 1'b1;
    send_set(16'h1860, 16'h060C, 18'h03854, 4'd3);
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early: out_valid got %b want 0 one edge after mid", out_valid); end
    @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_latency: out_valid got %b want 1", out_valid); end
    total++; if (out_product !== 32'h06260060) begin bad++; $display("FAIL basic_product: got %h want 06260060", out_product); end
    total++; if (out_tag !== 4'd3) begin bad++; $display("FAIL basic_tag: got %0d want 3", out_tag); end
    total++; if (out_err !== 1'b0) begin bad++; $display("FAIL basic_err: got %b want 0", out_err); end
    @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_single: out_valid got %b want 0", out_valid); end
    repeat (2) @(posedge clk);
    #1;
    clear_q();
  endtask

  task automatic test_back_to_back();
    logic [31:0] ep[3];
    logic [3:0]  et[3];
    ep = '{32'h06260060, 32'hFFFE0001, 32'h00030A08};
    et = '{4'd1, 4'd2, 4'd5};
    clear_q();
    out_ready = 1'b1;
    send_set(16'h1860, 16'h060C, 18'h03854, 4'd1);
    // 0xFFFF^2: lo = hi = 0xFF*0xFF, mid = (0xFF+0xFF)^2 = 0x3F804
    send_set(16'hFE01, 16'hFE01, 18'h3F804, 4'd2);
    // 0x0102 * 0x0304: lo = 2*4, hi = 1*3, mid = 3*7
    send_set(16'h0008, 16'h0003, 18'h00015, 4'd5);
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    total++; if (q_prod.size() != 3) begin bad++; $display("FAIL b2b_count: got %0d results want 3", q_prod.size()); end
    for (int i = 0; i < 3 && i < q_prod.size(); i++) begin
      total++; if (q_prod[i] !== ep[i]) begin bad++; $display("FAIL b2b_product[%0d]: got %h want %h", i, q_prod[i], ep[i]); end
      total++; if (q_tag[i] !== et[i]) begin bad++; $display("FAIL b2b_tag[%0d]: got %0d want %0d", i, q_tag[i], et[i]); end
      total++; if (q_err[i] !== 1'b0) begin bad++; $display("FAIL b2b_err[%0d]: got %b want 0", i, q_err[i]); end
      if (i > 0) begin
        total++; if (q_cyc[i] - q_cyc[i-1] != 3) begin bad++; $display("FAIL b2b_spacing[%0d]: got %0d cycles want 3", i, q_cyc[i] - q_cyc[i-1]); end
      end
    end
    clear_q();
  endtask

  task automatic test_backpressure();
    logic [31:0] ep[3];
    logic [3:0]  et[3];
    ep = '{32'h06260060, 32'h00030A08, 32'hFFFE0001};
    et = '{4'd3, 4'd6, 4'd7};
    clear_q();
    out_ready = 1'b0;
    send_set(16'h1860, 16'h060C, 18'h03854, 4'd3);
    send_set(16'h0008, 16'h0003, 18'h00015, 4'd6);
    send_beat({2'b11, 16'hFE01}, 4'hF);
    send_beat({2'b11, 16'hFE01}, 4'hE);
    in_valid = 1'b1;
    in_data  = 18'h3F804;
    in_tag   = 4'd7;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", k, in_ready); end
      total++; if (out_valid !== 1'b1 || out_product !== 32'h06260060) begin
        bad++; $display("FAIL bp_hold[%0d]: valid %b product %h want 1 06260060", k, out_valid, out_product);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_beat(18'h3F804, 4'd7);
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    total++; if (q_prod.size() != 3) begin bad++; $display("FAIL bp_count: got %0d results want 3", q_prod.size()); end
    for (int i = 0; i < 3 && i < q_prod.size(); i++) begin
      total++; if (q_prod[i] !== ep[i]) begin bad++; $display("FAIL bp_product[%0d]: got %h want %h", i, q_prod[i], ep[i]); end
      total++; if (q_tag[i] !== et[i]) begin bad++; $display("FAIL bp_tag[%0d]: got %0d want %0d", i, q_tag[i], et[i]); end
    end
    clear_q();
  endtask

  task automatic test_malformed();
    clear_q();
    out_ready = 1'b1;
    // corr = 1 - 0x20 wraps to 0x3FFE1; 0x00100010 + 0x3FFE100 = 0x040FE110
    send_set(16'h0010, 16'h0010, 18'h00001, 4'd9);
    send_set(16'h1860, 16'h060C, 18'h03854, 4'd10);
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    total++; if (q_prod.size() != 2) begin bad++; $display("FAIL mal_count: got %0d results want 2", q_prod.size()); end
    if (q_prod.size() >= 2) begin
      total++; if (q_err[0] !== 1'b1) begin bad++; $display("FAIL mal_err: got %b want 1", q_err[0]); end
      total++; if (q_prod[0] !== 32'h040FE110) begin bad++; $display("FAIL mal_product: got %h want 040FE110", q_prod[0]); end
      total++; if (q_tag[0] !== 4'd9) begin bad++; $display("FAIL mal_tag: got %0d want 9", q_tag[0]); end
      total++; if (q_err[1] !== 1'b0) begin bad++; $display("FAIL mal_next_err: got %b want 0", q_err[1]); end
      total++; if (q_prod[1] !== 32'h06260060) begin bad++; $display("FAIL mal_next_product: got %h want 06260060", q_prod[1]); end
    end
    clear_q();
  endtask

  task automatic test_reset_mid();
    clear_q();
    out_ready = 1'b0;
    send_set(16'h1860, 16'h060C, 18'h03854, 4'd4);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rst_pre_valid: got %b want 1", out_valid); end
    send_beat({2'b00, 16'h1111}, 4'h0);
    send_beat({2'b00, 16'h2222}, 4'h0);
    in_valid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    total++; if (out_product !== 32'h0) begin bad++; $display("FAIL rst_product: got %h want 0", out_product); end
    total++; if (out_tag !== 4'h0) begin bad++; $display("FAIL rst_tag: got %h want 0", out_tag); end
    total++; if (out_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", out_err); end
    @(negedge clk);
    rstn = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0 || q_prod.size() != 0) begin
      bad++; $display("FAIL rst_no_pulse: valid %b results %0d want 0 0", out_valid, q_prod.size());
    end
    send_set(16'h0008, 16'h0003, 18'h00015, 4'd6);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++; if (q_prod.size() != 1) begin bad++; $display("FAIL rst_fresh_count: got %0d results want 1", q_prod.size()); end
    if (q_prod.size() >= 1) begin
      total++; if (q_prod[0] !== 32'h00030A08) begin bad++; $display("FAIL rst_fresh_product: got %h want 00030A08", q_prod[0]); end
      total++; if (q_tag[0] !== 4'd6) begin bad++; $display("FAIL rst_fresh_tag: got %0d want 6", q_tag[0]); end
    end
    clear_q();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_malformed();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
